// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache request responder.
//   - FSM state encoding for the request sequencer
//   - default geometry (address/word/index widths) and derived tag width
//   - byte_merge(): overlays the enabled bytes of a new word onto an old word
package cache_pkg;

    localparam int ADDR_SIZE_DEF  = 16;
    localparam int WORD_SIZE_DEF  = 32;
    localparam int INDEX_BITS_DEF = 4;
    localparam int TAG_BITS_DEF   = ADDR_SIZE_DEF - INDEX_BITS_DEF;
    localparam int BVAL_BITS      = WORD_SIZE_DEF / 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Byte i of the result comes from new_word when bval[i] is set,
    // otherwise from old_word.
    function automatic logic [WORD_SIZE_DEF-1:0] byte_merge(
        input logic [WORD_SIZE_DEF-1:0] old_word,
        input logic [WORD_SIZE_DEF-1:0] new_word,
        input logic [BVAL_BITS-1:0]     bval
    );
        logic [WORD_SIZE_DEF-1:0] res;
        res = old_word;
        for (int i = 0; i < BVAL_BITS; i++) begin
            if (bval[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: direct-mapped, one-word-per-line storage.
// Ports:
//   clk, rst_n             clock; async active-low reset clears valid bits only
//   lk_idx/lk_tag          combinational lookup -> lk_hit, lk_data
//   fill_en/idx/tag/data   synchronous line fill (sets valid, tag, data)
//   wr_en/idx/data/bval    synchronous byte-masked update of line data
module cache_line_array
    import cache_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = TAG_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  lk_idx,
    input  logic [TAG_BITS-1:0]    lk_tag,
    output logic                   lk_hit,
    output logic [WORD_SIZE-1:0]   lk_data,
    input  logic                   fill_en,
    input  logic [INDEX_BITS-1:0]  fill_idx,
    input  logic [TAG_BITS-1:0]    fill_tag,
    input  logic [WORD_SIZE-1:0]   fill_data,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_idx,
    input  logic [WORD_SIZE-1:0]   wr_data,
    input  logic [WORD_SIZE/8-1:0] wr_bval
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [WORD_SIZE-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end else if (wr_en) begin
            data_q[wr_idx] <= byte_merge(data_q[wr_idx], wr_data, wr_bval);
        end
    end

    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_data = data_q[lk_idx];

endmodule

// File: rtl/cache_req_responder.sv
// cache_req_responder: cache-domain end of the CPU<->cache request link.
// Serves single-cycle cache_rd/cache_wr pulses from a direct-mapped,
// write-through, no-write-allocate word cache backed by a memory port.
// Ports:
//   cache_clk, cache_rst_n         clock, async active-low reset
//   cache_addr/wdata/bval/rd/wr    request in (one-cycle pulses)
//   cache_ack, cache_rdata         one-cycle completion, held read data
//   mem_addr/wdata/bval/rd/wr      memory request (level until mem_ack)
//   mem_ack, mem_rdata             memory completion
//   req_overrun                    sticky: request seen while busy, or rd+wr together
//   hit_cnt, miss_cnt              saturating read hit/miss counters
module cache_req_responder
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic                   cache_clk,
    input  logic                   cache_rst_n,
    input  logic [ADDR_SIZE-1:0]   cache_addr,
    input  logic [WORD_SIZE-1:0]   cache_wdata,
    input  logic [WORD_SIZE/8-1:0] cache_bval,
    input  logic                   cache_rd,
    input  logic                   cache_wr,
    output logic                   cache_ack,
    output logic [WORD_SIZE-1:0]   cache_rdata,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    output logic [WORD_SIZE/8-1:0] mem_bval,
    output logic                   mem_rd,
    output logic                   mem_wr,
    input  logic                   mem_ack,
    input  logic [WORD_SIZE-1:0]   mem_rdata,
    output logic                   req_overrun,
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt
);

    localparam int TAG_BITS = ADDR_SIZE - INDEX_BITS;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [WORD_SIZE/8-1:0] bval_q, bval_d;
    logic                   is_wr_q, is_wr_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic                   overrun_q, overrun_d;
    logic [15:0]            hit_cnt_q, hit_cnt_d;
    logic [15:0]            miss_cnt_q, miss_cnt_d;
    logic                   ack_q, mem_rd_q, mem_wr_q;

    logic                   lk_hit;
    logic [WORD_SIZE-1:0]   lk_data;
    logic                   fill_en, arr_wr_en;

    cache_line_array #(
        .WORD_SIZE  (WORD_SIZE),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk       (cache_clk),
        .rst_n     (cache_rst_n),
        .lk_idx    (addr_q[INDEX_BITS-1:0]),
        .lk_tag    (addr_q[ADDR_SIZE-1:INDEX_BITS]),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .fill_en   (fill_en),
        .fill_idx  (addr_q[INDEX_BITS-1:0]),
        .fill_tag  (addr_q[ADDR_SIZE-1:INDEX_BITS]),
        .fill_data (mem_rdata),
        .wr_en     (arr_wr_en),
        .wr_idx    (addr_q[INDEX_BITS-1:0]),
        .wr_data   (wdata_q),
        .wr_bval   (bval_q)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bval_d     = bval_q;
        is_wr_d    = is_wr_q;
        rdata_d    = rdata_q;
        overrun_d  = overrun_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fill_en    = 1'b0;
        arr_wr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cache_rd || cache_wr) begin
                    addr_d  = cache_addr;
                    wdata_d = cache_wdata;
                    bval_d  = cache_bval;
                    // A simultaneous rd+wr is served as the write.
                    is_wr_d = cache_wr;
                    state_d = ST_LOOKUP;
                    if (cache_rd && cache_wr) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            ST_LOOKUP: begin
                if (!is_wr_q) begin
                    if (lk_hit) begin
                        rdata_d = lk_data;
                        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                        state_d = ST_RESP;
                    end else begin
                        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                        state_d = ST_MEM_RD;
                    end
                end else if (bval_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    // Write-through, no allocate: only a resident line is updated.
                    arr_wr_en = lk_hit;
                    state_d   = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    fill_en = 1'b1;
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && (cache_rd || cache_wr)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge cache_clk or negedge cache_rst_n) begin
        if (!cache_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            bval_q     <= '0;
            is_wr_q    <= 1'b0;
            rdata_q    <= '0;
            overrun_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            ack_q      <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bval_q     <= bval_d;
            is_wr_q    <= is_wr_d;
            rdata_q    <= rdata_d;
            overrun_q  <= overrun_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            // Strobes are registered copies of the next state, so they are
            // high exactly while the FSM sits in the matching state.
            ack_q      <= (state_d == ST_RESP);
            mem_rd_q   <= (state_d == ST_MEM_RD);
            mem_wr_q   <= (state_d == ST_MEM_WR);
        end
    end

    assign cache_ack   = ack_q;
    assign cache_rdata = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_bval    = bval_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign req_overrun = overrun_q;
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_cache_req_responder.sv
// Directed bench for cache_req_responder with a bench-side memory responder
// and an expected-rdata queue checked on every cache_ack.
module tb_cache_req_responder;

    logic        cache_clk;
    logic        cache_rst_n;
    logic [15:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_bval;
    logic        cache_rd;
    logic        cache_wr;
    logic        cache_ack;
    logic [31:0] cache_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bval;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        req_overrun;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    cache_req_responder dut (
        .cache_clk   (cache_clk),
        .cache_rst_n (cache_rst_n),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_bval  (cache_bval),
        .cache_rd    (cache_rd),
        .cache_wr    (cache_wr),
        .cache_ack   (cache_ack),
        .cache_rdata (cache_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_bval    (mem_bval),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .req_overrun (req_overrun),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    // clock
    initial cache_clk = 1'b0;
    always #5 cache_clk = ~cache_clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata  = 32'h0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge cache_clk);
        #1;
    endtask

    // Issue one request pulse and watch 30 cycles: answer memory after mem_lat
    // cycles, count acks, compare rdata against the scoreboard at each ack.
    // inject_at > 0 raises a stray cache_rd during that relative cycle.
    task automatic run_req(input string name, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] bv, input int mem_lat,
                           input logic [31:0] mem_data, input logic [31:0] exp_rd_data,
                           input int exp_lat, input logic exp_mrd, input logic exp_mwr,
                           input int inject_at);
        int          ack_cnt  = 0;
        int          ack_at   = -1;
        int          req_at   = -1;
        logic        saw_rd   = 1'b0;
        logic        saw_wr   = 1'b0;
        logic        mem_done = 1'b0;
        logic [15:0] m_addr   = '0;
        logic [31:0] m_wdata  = '0;
        logic [3:0]  m_bval   = '0;

        if (rd && !wr) begin
            exp_q.push_back(exp_rd_data);
            last_rdata = exp_rd_data;
        end else begin
            exp_q.push_back(last_rdata);
        end

        cache_addr  = addr;
        cache_wdata = wd;
        cache_bval  = bv;
        cache_rd    = rd;
        cache_wr    = wr;
        for (int c = 1; c <= 30; c++) begin
            tick();
            cache_rd = 1'b0;
            cache_wr = 1'b0;
            mem_ack  = 1'b0;
            if (c == inject_at) cache_rd = 1'b1;
            if (cache_ack) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = c;
                if (exp_q.size() > 0) chk({name, ".rdata"}, cache_rdata, exp_q.pop_front());
                else chk({name, ".extra_ack"}, 32'(ack_cnt), 32'd1);
            end
            if (mem_rd && !saw_rd) begin
                saw_rd = 1'b1;
                req_at = c;
                m_addr = mem_addr;
            end
            if (mem_wr && !saw_wr) begin
                saw_wr  = 1'b1;
                req_at  = c;
                m_addr  = mem_addr;
                m_wdata = mem_wdata;
                m_bval  = mem_bval;
            end
            if ((mem_rd || mem_wr) && !mem_done && c == req_at + mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_data;
                mem_done  = 1'b1;
            end
        end
        mem_ack = 1'b0;

        chk({name, ".ack_lat"}, 32'(ack_at), 32'(exp_lat));
        chk({name, ".ack_cnt"}, 32'(ack_cnt), 32'd1);
        chk({name, ".mem_rd_seen"}, 32'(saw_rd), 32'(exp_mrd));
        chk({name, ".mem_wr_seen"}, 32'(saw_wr), 32'(exp_mwr));
        if (saw_rd || saw_wr) chk({name, ".mem_addr"}, 32'(m_addr), 32'(addr));
        if (saw_wr) begin
            chk({name, ".mem_wdata"}, m_wdata, wd);
            chk({name, ".mem_bval"}, 32'(m_bval), 32'(bv));
        end
        chk({name, ".sb_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int acks;
        int rd_seen;

        cache_rst_n = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        cache_bval  = '0;
        cache_rd    = 1'b0;
        cache_wr    = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        repeat (3) @(posedge cache_clk);
        #1;
        cache_rst_n = 1'b1;
        tick();

        // reset state
        chk("rst.ack", 32'(cache_ack), 32'd0);
        chk("rst.rdata", cache_rdata, 32'h0);
        chk("rst.mem_rd", 32'(mem_rd), 32'd0);
        chk("rst.mem_wr", 32'(mem_wr), 32'd0);
        chk("rst.overrun", 32'(req_overrun), 32'd0);
        chk("rst.hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst.miss_cnt", 32'(miss_cnt), 32'd0);

        // read miss, mem answers 2 cycles after mem_rd rises: ack at N+5
        run_req("rd_miss", 1'b1, 1'b0, 16'h0012, 32'h0, 4'h0, 2, 32'hDEADBEEF,
                32'hDEADBEEF, 5, 1'b1, 1'b0, 0);
        chk("rd_miss.miss_cnt", 32'(miss_cnt), 32'd1);
        chk("rd_miss.hit_cnt", 32'(hit_cnt), 32'd0);

        // read hit: ack at N+2, no memory traffic
        run_req("rd_hit", 1'b1, 1'b0, 16'h0012, 32'h0, 4'h0, 0, 32'h0,
                32'hDEADBEEF, 2, 1'b0, 1'b0, 0);
        chk("rd_hit.hit_cnt", 32'(hit_cnt), 32'd1);

        // stray mem_ack while idle must do nothing
        acks = 0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cache_ack) acks++;
        end
        chk("idle_mem_ack.acks", 32'(acks), 32'd0);
        chk("idle_mem_ack.rdata", cache_rdata, 32'hDEADBEEF);

        // write hit, partial bytes: line merged, memory written, rdata untouched
        run_req("wr_hit", 1'b0, 1'b1, 16'h0012, 32'h11223344, 4'b0101, 1, 32'h0,
                32'h0, 4, 1'b0, 1'b1, 0);
        run_req("rd_merged", 1'b1, 1'b0, 16'h0012, 32'h0, 4'h0, 0, 32'h0,
                32'hDE22BE44, 2, 1'b0, 1'b0, 0);
        chk("rd_merged.hit_cnt", 32'(hit_cnt), 32'd2);

        // write miss on same index, other tag: mem only, line kept
        run_req("wr_miss", 1'b0, 1'b1, 16'h0022, 32'hCAFEF00D, 4'hF, 0, 32'h0,
                32'h0, 3, 1'b0, 1'b1, 0);
        run_req("rd_kept", 1'b1, 1'b0, 16'h0012, 32'h0, 4'h0, 0, 32'h0,
                32'hDE22BE44, 2, 1'b0, 1'b0, 0);
        chk("rd_kept.hit_cnt", 32'(hit_cnt), 32'd3);
        chk("rd_kept.overrun", 32'(req_overrun), 32'd0);

        // rd+wr together: served as write, overrun set
        run_req("rd_wr_both", 1'b1, 1'b1, 16'h0040, 32'hA5A5A5A5, 4'b0011, 0, 32'h0,
                32'h0, 3, 1'b0, 1'b1, 0);
        chk("rd_wr_both.overrun", 32'(req_overrun), 32'd1);
        chk("rd_wr_both.miss_cnt", 32'(miss_cnt), 32'd1);

        // read miss with a stray cache_rd during MEM_RD: still exactly one ack
        run_req("rd_busy", 1'b1, 1'b0, 16'h0035, 32'h0, 4'h0, 3, 32'h55AA55AA,
                32'h55AA55AA, 6, 1'b1, 1'b0, 3);
        chk("rd_busy.overrun_held", 32'(req_overrun), 32'd1);
        chk("rd_busy.miss_cnt", 32'(miss_cnt), 32'd2);

        // write with bval=0: ack at N+2, no memory write, line untouched
        run_req("wr_bval0", 1'b0, 1'b1, 16'h0012, 32'hFFFFFFFF, 4'h0, 0, 32'h0,
                32'h0, 2, 1'b0, 1'b0, 0);
        run_req("rd_after_b0", 1'b1, 1'b0, 16'h0012, 32'h0, 4'h0, 0, 32'h0,
                32'hDE22BE44, 2, 1'b0, 1'b0, 0);
        chk("rd_after_b0.hit_cnt", 32'(hit_cnt), 32'd4);

        // reset during MEM_RD aborts the access
        cache_addr = 16'h0077;
        cache_rd   = 1'b1;
        tick();
        cache_rd = 1'b0;
        tick();
        chk("abort.mem_rd_before", 32'(mem_rd), 32'd1);
        tick();
        cache_rst_n = 1'b0;
        #1;
        chk("abort.mem_rd", 32'(mem_rd), 32'd0);
        chk("abort.ack", 32'(cache_ack), 32'd0);
        chk("abort.overrun", 32'(req_overrun), 32'd0);
        chk("abort.hit_cnt", 32'(hit_cnt), 32'd0);
        chk("abort.miss_cnt", 32'(miss_cnt), 32'd0);
        chk("abort.rdata", cache_rdata, 32'h0);
        tick();
        tick();
        cache_rst_n = 1'b1;
        last_rdata  = 32'h0;
        acks    = 0;
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cache_ack) acks++;
            if (mem_rd) rd_seen++;
        end
        chk("abort.no_ack", 32'(acks), 32'd0);
        chk("abort.no_mem_rd", 32'(rd_seen), 32'd0);

        // valid bits cleared: previously resident line misses; stray rd while busy
        run_req("rd_post_rst", 1'b1, 1'b0, 16'h0012, 32'h0, 4'h0, 1, 32'h01020304,
                32'h01020304, 4, 1'b1, 1'b0, 2);
        chk("rd_post_rst.miss_cnt", 32'(miss_cnt), 32'd1);
        chk("rd_post_rst.hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rd_post_rst.overrun", 32'(req_overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
